// File: rtl/enc_input_conditioner_if.sv
// Encoder conditioner signal bundle.
// The raw encoder input plus the cleaned level and edge strobes.
// With ENC_GLITCH_CNT_EN defined, the bundle also carries the rejected-glitch count.
// The master side (the environment) drives enc_in and observes the outputs.
// The slave side (the conditioner) does the opposite.
interface enc_input_conditioner_if
`ifdef ENC_GLITCH_CNT_EN
    #(parameter int GLITCH_CNT_W = 16)
`endif
    ;
    logic enc_in;
    logic data;
    logic rise;
    logic fall;
`ifdef ENC_GLITCH_CNT_EN
    logic [GLITCH_CNT_W-1:0] glitch_cnt;

    modport master (output enc_in, input data, rise, fall, glitch_cnt);
    modport slave  (input enc_in, output data, rise, fall, glitch_cnt);
`else
    modport master (output enc_in, input data, rise, fall);
    modport slave  (input enc_in, output data, rise, fall);
`endif
endinterface

// File: rtl/enc_input_conditioner.sv
// Encoder input conditioner.
// Synchronises the raw encoder channel and rejects excursions shorter than
// FILTER_CYCLES synchronised samples. It then presents a clean registered level
// with one-cycle rise and fall strobes.
// Optional feature: define ENC_GLITCH_CNT_EN to add a saturating count of
// rejected glitches (bus.glitch_cnt).
module enc_input_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 10,
    parameter int GLITCH_CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    enc_input_conditioner_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE_LOW,
        CHECK_HIGH,
        IDLE_HIGH,
        CHECK_LOW
    } state_t;

    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_data;
    logic                   r_rise;
    logic                   r_fall;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.enc_in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Accept a new level only after FILTER_CYCLES consecutive samples of it; strobes last one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_data  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                IDLE_LOW: begin
                    if (w_s) begin
                        if (FILTER_CYCLES == 1) begin
                            r_state <= IDLE_HIGH;
                            r_cnt   <= '0;
                            r_data  <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_state <= CHECK_HIGH;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                CHECK_HIGH: begin
                    if (!w_s) begin
                        r_state <= IDLE_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE_HIGH;
                        r_cnt   <= '0;
                        r_data  <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!w_s) begin
                        if (FILTER_CYCLES == 1) begin
                            r_state <= IDLE_LOW;
                            r_cnt   <= '0;
                            r_data  <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_state <= CHECK_LOW;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                CHECK_LOW: begin
                    if (w_s) begin
                        r_state <= IDLE_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE_LOW;
                        r_cnt   <= '0;
                        r_data  <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE_LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.data = r_data;
    assign bus.rise = r_rise;
    assign bus.fall = r_fall;

`ifdef ENC_GLITCH_CNT_EN
    logic [GLITCH_CNT_W-1:0] r_glitchCnt;
    logic                    w_abort;

    assign w_abort = ((r_state == CHECK_HIGH) && !w_s) ||
                     ((r_state == CHECK_LOW)  &&  w_s);

    // Count aborted checks, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_glitchCnt <= '0;
        end else if (w_abort && (r_glitchCnt != '1)) begin
            r_glitchCnt <= r_glitchCnt + GLITCH_CNT_W'(1);
        end
    end

    assign bus.glitch_cnt = r_glitchCnt;
`endif

endmodule
